// File: rtl/servo_pkg.sv
// Shared constants and arithmetic helpers for the servo PWM array.
// Register offsets are relative to the first register after the targets.
package servo_pkg;

    localparam int REG_ENABLE = 0;
    localparam int REG_SLEW   = 1;
    localparam int REG_STATUS = 2;

    function automatic int clamp_us(int v, int lo, int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int slew_step(int cur, int tgt, int slew);
        int d;
        d = tgt - cur;
        if (slew == 0 || (d <= slew && -d <= slew)) return tgt;
        if (d > 0) return cur + slew;
        return cur - slew;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: frame-latched enable, slewed width, registered compare.
// Width and enable move only at frame boundaries so a pulse never glitches.
module servo_channel
    import servo_pkg::*;
#(
    parameter int               POS_W  = 16,
    parameter int               CNT_W  = 15,
    parameter logic [POS_W-1:0] RST_US = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_start,
    input  logic             enable,
    input  logic [POS_W-1:0] target,
    input  logic [POS_W-1:0] slew,
    input  logic [CNT_W-1:0] us_cnt,
    output logic [POS_W-1:0] current,
    output logic             pwm
);

    logic en_act;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            current <= RST_US;
            en_act  <= 1'b0;
            pwm     <= 1'b0;
        end else begin
            if (frame_start) begin
                en_act  <= enable;
                current <= POS_W'(slew_step(int'(current), int'(target),
                                            int'(slew)));
            end
            pwm <= en_act && (32'(us_cnt) < 32'(current));
        end
    end

endmodule

// File: rtl/servo_pwm_array.sv
// N-channel hobby-servo PWM generator with an Avalon-MM register file.
// Microsecond prescaler and frame counter are shared by all channels.
module servo_pwm_array
    import servo_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CLK_HZ   = 50_000_000,
    parameter int FRAME_US = 20000,
    parameter int MIN_US   = 1000,
    parameter int MAX_US   = 2000,
    parameter int POS_W    = 16,
    parameter int ADDR_W   = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       avs_address,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    input  logic                    avs_read,
    output logic [31:0]             avs_readdata,
    output logic [NUM_CH-1:0]       servo_pwm,
    output logic [NUM_CH*POS_W-1:0] pos_export,
    output logic                    frame_start
);

    localparam int PRE   = CLK_HZ / 1_000_000;
    localparam int CNT_W = $clog2(FRAME_US + 1);
    localparam logic [POS_W-1:0] MID = POS_W'((MIN_US + MAX_US) / 2);

    logic [31:0]       pre_cnt;
    logic [CNT_W-1:0]  us_cnt;
    logic              us_tick;
    logic [POS_W-1:0]  target  [NUM_CH];
    logic [POS_W-1:0]  current [NUM_CH];
    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] status;
    logic [POS_W-1:0]  slew;
    logic [31:0]       rdata;
    logic [31:0]       tgt_rd;
    int                addr;
    logic              unused_wdata;

    assign addr         = int'(avs_address);
    assign unused_wdata = ^avs_writedata;
    assign us_tick      = (pre_cnt == 32'(PRE - 1));
    assign frame_start  = us_tick && (us_cnt == CNT_W'(FRAME_US - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            us_cnt  <= '0;
        end else begin
            pre_cnt <= us_tick ? '0 : pre_cnt + 32'd1;
            if (us_tick)
                us_cnt <= frame_start ? '0 : us_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++)
                target[i] <= MID;
            enable <= '0;
            slew   <= '0;
        end else if (avs_write) begin
            for (int i = 0; i < NUM_CH; i++)
                if (addr == i)
                    target[i] <= POS_W'(clamp_us(
                        int'(avs_writedata[POS_W-1:0]), MIN_US, MAX_US));
            if (addr == NUM_CH + REG_ENABLE)
                enable <= avs_writedata[NUM_CH-1:0];
            if (addr == NUM_CH + REG_SLEW)
                slew <= avs_writedata[POS_W-1:0];
        end
    end

    always_comb begin
        tgt_rd = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (addr == i)
                tgt_rd = 32'(target[i]);
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            (addr < NUM_CH):               rdata = tgt_rd;
            (addr == NUM_CH + REG_ENABLE): rdata = 32'(enable);
            (addr == NUM_CH + REG_SLEW):   rdata = 32'(slew);
            (addr == NUM_CH + REG_STATUS): rdata = 32'(status);
            default:                       rdata = '0;
        endcase
    end

    // Sampled before this cycle's write lands, so read+write returns old data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            avs_readdata <= '0;
        else if (avs_read)
            avs_readdata <= rdata;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        servo_channel #(
            .POS_W  (POS_W),
            .CNT_W  (CNT_W),
            .RST_US (MID)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .frame_start (frame_start),
            .enable      (enable[g]),
            .target      (target[g]),
            .slew        (slew),
            .us_cnt      (us_cnt),
            .current     (current[g]),
            .pwm         (servo_pwm[g])
        );
        assign status[g] = (current[g] != target[g]);
        assign pos_export[g*POS_W +: POS_W] = current[g];
    end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Self-checking bench for servo_pwm_array: register vectors, corner
// sequences and randomized traffic against a frame-level reference model.
module tb_servo_pwm_array;

    localparam int NUM_CH   = 4;
    localparam int CLK_HZ   = 4_000_000;
    localparam int FRAME_US = 100;
    localparam int MIN_US   = 10;
    localparam int MAX_US   = 50;
    localparam int POS_W    = 16;
    localparam int ADDR_W   = 3;
    localparam int PRE      = CLK_HZ / 1_000_000;
    localparam int MID      = (MIN_US + MAX_US) / 2;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic [ADDR_W-1:0]       avs_address = '0;
    logic                    avs_write = 1'b0;
    logic [31:0]             avs_writedata = '0;
    logic                    avs_read = 1'b0;
    logic [31:0]             avs_readdata;
    logic [NUM_CH-1:0]       servo_pwm;
    logic [NUM_CH*POS_W-1:0] pos_export;
    logic                    frame_start;

    servo_pwm_array #(
        .NUM_CH   (NUM_CH),
        .CLK_HZ   (CLK_HZ),
        .FRAME_US (FRAME_US),
        .MIN_US   (MIN_US),
        .MAX_US   (MAX_US),
        .POS_W    (POS_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .servo_pwm     (servo_pwm),
        .pos_export    (pos_export),
        .frame_start   (frame_start)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int m_tgt [NUM_CH];
    int m_cur [NUM_CH];
    int m_en, m_en_act, m_slew;
    bit valid;

    int hc [NUM_CH];
    int last_hc [NUM_CH];

    typedef struct {
        bit w;
        bit r;
        int a;
        int d;
        int exp;
    } vec_t;

    vec_t tab [$];

    always @(negedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) hc[i] = 0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (servo_pwm[i]) hc[i]++;
            if (frame_start)
                for (int i = 0; i < NUM_CH; i++) begin
                    last_hc[i] = hc[i];
                    hc[i] = 0;
                end
        end
    end

    task automatic check(input string name, input longint act,
                         input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_tgt[i] = MID;
            m_cur[i] = MID;
        end
        m_en = 0;
        m_en_act = 0;
        m_slew = 0;
        valid = 0;
    endtask

    task automatic model_write(input int a, input int d);
        int v;
        v = d & 'hFFFF;
        if (a < NUM_CH)
            m_tgt[a] = (v < MIN_US) ? MIN_US : (v > MAX_US) ? MAX_US : v;
        else if (a == NUM_CH)
            m_en = d & ((1 << NUM_CH) - 1);
        else if (a == NUM_CH + 1)
            m_slew = v;
    endtask

    function automatic int model_status();
        int s = 0;
        for (int i = 0; i < NUM_CH; i++)
            if (m_cur[i] != m_tgt[i]) s |= (1 << i);
        return s;
    endfunction

    function automatic int model_read(input int a);
        if (a < NUM_CH) return m_tgt[a];
        if (a == NUM_CH) return m_en;
        if (a == NUM_CH + 1) return m_slew;
        if (a == NUM_CH + 2) return model_status();
        return 0;
    endfunction

    task automatic bus(input bit w, input bit r, input int a, input int d,
                       output int rd);
        avs_address   = a[ADDR_W-1:0];
        avs_write     = w;
        avs_read      = r;
        avs_writedata = d;
        @(negedge clk);
        avs_write = 1'b0;
        avs_read  = 1'b0;
        rd = int'(avs_readdata);
        if (w) model_write(a, d);
    endtask

    task automatic wr(input int a, input int d);
        int rd;
        bus(1'b1, 1'b0, a, d, rd);
    endtask

    task automatic rd_reg(input int a, output int v);
        bus(1'b0, 1'b1, a, 0, v);
    endtask

    // Pulses of the ended frame are checked, then the model steps one frame
    task automatic wait_frame();
        int n = 0;
        int d;
        while (!frame_start && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) begin
            check("frame_timeout", 0, 1);
            return;
        end
        @(negedge clk);
        #1;
        if (valid)
            for (int i = 0; i < NUM_CH; i++)
                check($sformatf("pulse_ch%0d", i), last_hc[i],
                      ((m_en_act >> i) & 1) ? m_cur[i] * PRE : 0);
        m_en_act = m_en;
        for (int i = 0; i < NUM_CH; i++) begin
            d = m_tgt[i] - m_cur[i];
            if (m_slew == 0 || (d <= m_slew && -d <= m_slew))
                m_cur[i] = m_tgt[i];
            else
                m_cur[i] = m_cur[i] + ((d > 0) ? m_slew : -m_slew);
        end
        valid = 1;
        for (int i = 0; i < NUM_CH; i++)
            check($sformatf("pos_ch%0d", i),
                  pos_export[i*POS_W +: POS_W], m_cur[i]);
    endtask

    task automatic run_tab();
        int rd;
        foreach (tab[k]) begin
            bus(tab[k].w, tab[k].r, tab[k].a, tab[k].d, rd);
            if (tab[k].r)
                check($sformatf("vec%0d_a%0d", k, tab[k].a), rd, tab[k].exp);
        end
        tab.delete();
    endtask

    initial begin
        int v, a, d, nw, n;

        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_pwm", servo_pwm, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_readdata", avs_readdata, 0);
        for (int i = 0; i < NUM_CH; i++)
            check("rst_pos", pos_export[i*POS_W +: POS_W], MID);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset register values
        for (int i = 0; i < 8; i++)
            tab.push_back('{1'b0, 1'b1, i, 0, (i < NUM_CH) ? MID : 0});
        run_tab();
        wait_frame();
        wait_frame();
        wait_frame();

        // Clamping, ignored addresses, read-during-write
        tab.push_back('{1'b1, 1'b0, 7, 'h55, 0});
        tab.push_back('{1'b0, 1'b1, 7, 0, 0});
        tab.push_back('{1'b1, 1'b0, 6, 'hF, 0});
        tab.push_back('{1'b0, 1'b1, 6, 0, 0});
        tab.push_back('{1'b0, 1'b1, 4, 0, 0});
        tab.push_back('{1'b1, 1'b1, 5, 3, 0});
        tab.push_back('{1'b0, 1'b1, 5, 0, 3});
        tab.push_back('{1'b1, 1'b0, 5, 0, 0});
        tab.push_back('{1'b0, 1'b1, 5, 0, 0});
        tab.push_back('{1'b1, 1'b0, 1, 5, 0});
        tab.push_back('{1'b0, 1'b1, 1, 0, 10});
        tab.push_back('{1'b1, 1'b0, 2, 900, 0});
        tab.push_back('{1'b0, 1'b1, 2, 0, 50});
        tab.push_back('{1'b0, 1'b1, 6, 0, 6});
        tab.push_back('{1'b1, 1'b1, 1, 40, 10});
        tab.push_back('{1'b0, 1'b1, 1, 0, 40});
        tab.push_back('{1'b1, 1'b0, 4, 'hFF, 0});
        tab.push_back('{1'b0, 1'b1, 4, 0, 'hF});
        run_tab();

        // Mid-frame target change waits for the next frame
        wait_frame();
        repeat (100) @(negedge clk);
        wr(0, 20);
        wait_frame();
        check("ch0_keeps_30", last_hc[0], 120);
        check("pos0_20", pos_export[15:0], 20);
        wait_frame();
        check("ch0_80clk", last_hc[0], 80);
        check("ch1_40us", last_hc[1], 160);
        check("ch2_50us", last_hc[2], 200);

        // Slew limiting
        wr(5, 7);
        wr(3, 50);
        wait_frame();
        check("slew_37", pos_export[63:48], 37);
        rd_reg(6, v);
        check("status3_a", (v >> 3) & 1, 1);
        wait_frame();
        check("slew_44", pos_export[63:48], 44);
        rd_reg(6, v);
        check("status3_b", (v >> 3) & 1, 1);
        wait_frame();
        check("slew_50", pos_export[63:48], 50);
        rd_reg(6, v);
        check("status3_c", (v >> 3) & 1, 0);

        // Asynchronous reset in the middle of a pulse
        n = 0;
        while (!servo_pwm[0] && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        check("pwm0_mid_pulse", servo_pwm[0], 1);
        reset_n = 1'b0;
        #1;
        check("rst_async_pwm", servo_pwm, 0);
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd_reg(i, v);
            check($sformatf("post_rst_a%0d", i), v, model_read(i));
        end
        for (int i = 0; i < NUM_CH; i++)
            check("post_rst_pos", pos_export[i*POS_W +: POS_W], MID);

        // Randomized traffic against the frame model
        wait_frame();
        for (int it = 0; it < 25; it++) begin
            nw = $urandom_range(1, 3);
            for (int k = 0; k < nw; k++) begin
                a = $urandom_range(0, 7);
                if (a < NUM_CH) d = $urandom_range(0, 70);
                else if (a == NUM_CH + 1) d = $urandom_range(0, 12);
                else d = $urandom;
                wr(a, d);
            end
            a = $urandom_range(0, 7);
            d = model_read(a);
            rd_reg(a, v);
            check($sformatf("rnd_rd_a%0d", a), v, d);
            wait_frame();
            rd_reg(6, v);
            check("rnd_status", v, model_status());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
